// File: rtl/timer_pkg.sv
// Shared types for the timer controller: FSM state encoding and counting mode.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_divider.sv
// Fixed clock prescaler: raises ev for one cycle every DIV enabled cycles.
module tick_divider #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic ev
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pre;

    // The phase only advances while enabled, so a pause keeps it intact.
    assign ev = en && (r_pre == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= ev ? '0 : r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Run/stop/reload controller for a WIDTH-bit down-counter with one-shot and
// periodic modes, a fixed prescaler and a one-cycle terminal-count tick.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_tick;

    logic w_en;
    logic w_clr;
    logic w_ev;
    logic w_last;
    logic w_cnt_nz;
    logic w_rel_nz;

    // A stop or load in the same cycle suppresses the decrement event.
    assign w_en     = (r_state == RUN) && !load && !stop;
    assign w_clr    = load || (start && !stop && ((r_state == IDLE) || (r_state == DONE)));
    assign w_last   = (r_count == WIDTH'(1));
    assign w_cnt_nz = |r_count;
    assign w_rel_nz = |r_reload;

    tick_divider #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (w_clr),
        .ev    (w_ev)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= MODE_ONESHOT;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (load) begin
                r_count  <= load_value;
                r_reload <= load_value;
                r_state  <= IDLE;
            end else if (stop) begin
                if (r_state == RUN) begin
                    r_state <= PAUSED;
                end
            end else begin
                case (r_state)
                    IDLE, PAUSED: begin
                        if (start && w_cnt_nz) begin
                            r_state <= RUN;
                            r_mode  <= periodic ? MODE_PERIODIC : MODE_ONESHOT;
                        end
                    end
                    DONE: begin
                        if (start && w_rel_nz) begin
                            r_count <= r_reload;
                            r_state <= RUN;
                            r_mode  <= periodic ? MODE_PERIODIC : MODE_ONESHOT;
                        end
                    end
                    RUN: begin
                        if (w_ev) begin
                            if (w_last) begin
                                r_tick <= 1'b1;
                                if (r_mode == MODE_PERIODIC) begin
                                    r_count <= r_reload;
                                end else begin
                                    r_count <= '0;
                                    r_state <= DONE;
                                end
                            end else if (w_cnt_nz) begin
                                r_count <= r_count - 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign count   = r_count;
    assign tick    = r_tick;
    assign running = (r_state == RUN);
    assign done    = (r_state == DONE);

endmodule
